vram_slot_sched: RTL and testbench
==================================

Name: vram_slot_sched

Overview:
- Time-division VRAM access scheduler driven by the video timing generator's HPOS/VPOS/HBLK/VBLK and the pixel clock enable.
- Each PCLK_EN strobe is one VRAM slot. Every slot is assigned to one of three requesters:
  - background tile fetch (BG)
  - sprite line fetch (SPR)
  - CPU
- Drives a single-port synchronous VRAM and returns read data to the slot's owner with a per-owner valid strobe.
- Sits between the timing generator, the tile/sprite renderers and the CPU bus.

Parameters:
- AW, 14, VRAM address width.
- DW, 8, VRAM data width.

Ports:
- CLK  in  1  system clock. At least 2 CLK per PCLK_EN strobe is guaranteed.
- RST_N  in  1  asynchronous, active-low reset.
- PCLK_EN  in  1  pixel clock enable; one slot per strobe.
- HPOS  in  9  horizontal pixel position from the timing generator.
- HBLK  in  1  horizontal blank.
- VBLK  in  1  vertical blank.
- BG_REQ  in  1  BG wants its current slot.
- BG_ADDR  in  AW  BG read address.
- SPR_REQ  in  1  SPR wants its current slot.
- SPR_ADDR  in  AW  SPR read address.
- CPU_REQ  in  1  CPU access request, level, held until CPU_ACK.
- CPU_WE  in  1  CPU write (1) / read (0).
- CPU_ADDR  in  AW  CPU address.
- CPU_WDATA  in  DW  CPU write data.
- CPU_ACK  out  1  one-CLK pulse: CPU access complete.
- CPU_RDATA  out  DW  CPU read data, valid at CPU_ACK and held until the next CPU read.
- MEM_ADDR  out  AW  VRAM address.
- MEM_WE  out  1  VRAM write enable.
- MEM_WDATA  out  DW  VRAM write data.
- MEM_RDATA  in  DW  VRAM read data, one CLK after address.
- RDATA  out  DW  read data returned to BG/SPR.
- BG_VALID  out  1  one-CLK pulse: RDATA belongs to BG.
- SPR_VALID  out  1  one-CLK pulse: RDATA belongs to SPR.

Behaviour:
- Reset (async, RST_N low): all outputs 0; owner pipeline = NONE; CPU FSM = IDLE. Reset mid-access aborts it: no ACK, no valid, no write.
- Slot class, evaluated combinationally on each PCLK_EN from current inputs:
  - VBLK=1: FREE.
  - Else HBLK=1: SPR, except HPOS[1:0]==3, which is FREE.
  - Else (active): BG when HPOS[2:0] is in {0,1,2,4,5,6}; FREE at HPOS[2:0] 3 and 7.
- Grant on each PCLK_EN:
  - BG slot and BG_REQ=1: BG.
  - SPR slot and SPR_REQ=1: SPR.
  - Otherwise CPU, if the CPU FSM is PEND.
  - Otherwise NONE.
  - An unrequested BG/SPR slot is donated to the CPU.
- Issue: on the grant CLK, register MEM_ADDR/MEM_WE/MEM_WDATA from the winner. MEM_WE=1 only for a CPU write. MEM_WE returns to 0 on the next CLK; MEM_ADDR holds.
- Return: owner latched alongside the address. One CLK after issue, MEM_RDATA is registered:
  - BG: into RDATA, BG_VALID=1.
  - SPR: into RDATA, SPR_VALID=1.
  - CPU read: into CPU_RDATA, CPU_ACK=1.
  - CPU write: CPU_ACK=1, RDATA and CPU_RDATA unchanged.
  - Valid and ack pulses last one CLK. Total latency grant to valid/ack = 2 CLK.
- CPU FSM:
  - IDLE -> PEND on CPU_REQ=1.
  - PEND -> BUSY on grant.
  - BUSY -> DONE on CPU_ACK.
  - DONE -> IDLE when CPU_REQ sampled 0. This prevents double issue on a held REQ.
  - CPU_WE/ADDR/WDATA are sampled at grant, not at REQ.
- Simultaneous events: BG/SPR never contend with each other (disjoint classes). CPU_REQ rising on the same CLK as a FREE-slot PCLK_EN is not granted that slot (FSM still IDLE).
- No PCLK_EN: no grants, outputs hold, return pipeline still completes.
- HPOS wrap and any blank transition take effect on the next PCLK_EN; nothing is cached from prior slots.

Test Plan:
- Reset: hold RST_N=0 with all REQs high and PCLK_EN toggling -> all outputs 0. Release -> first grant on the first PCLK_EN after release.
- Active line, BG_REQ=1 constant, HPOS 0..7:
  - BG_VALID asserts for HPOS 0,1,2,4,5,6.
  - No grant at HPOS 3 or 7 with the CPU idle.
  - RDATA equals RAM contents at BG_ADDR.
- CPU read 0x1234 issued at HPOS=1 (active):
  - Granted at HPOS=3, MEM_ADDR=0x1234.
  - CPU_ACK 2 CLK later with CPU_RDATA = RAM[0x1234].
  - No second issue while REQ stays high.
- CPU write 0x0100<=0xA5 with BG_REQ=0 at HPOS=0 -> granted at HPOS=0 (donated slot), MEM_WE pulse 1 CLK, read-back returns 0xA5.
- HBLK with SPR_REQ=1, HPOS 288..295:
  - SPR_VALID on all slots except HPOS 291 and 295.
  - A pending CPU request is granted at 291.
- VBLK, CPU issues 4 back-to-back writes (REQ dropped between each) -> each granted on the first PCLK_EN after PEND. Assert RST_N=0 during the third write's BUSY -> no ACK, and MEM_WE is 0 from the reset edge.

Source files
------------

// File: rtl/vram_slot_sched.sv
// VRAM slot scheduler: each pixel-clock strobe is one single-port VRAM slot shared
// between background fetch, sprite fetch and the CPU, with a two-CLK read return.
module vram_slot_sched #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PCLK_EN,
  input  logic [8:0]    HPOS,
  input  logic          HBLK,
  input  logic          VBLK,
  input  logic          BG_REQ,
  input  logic [AW-1:0] BG_ADDR,
  input  logic          SPR_REQ,
  input  logic [AW-1:0] SPR_ADDR,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [DW-1:0] RDATA,
  output logic          BG_VALID,
  output logic          SPR_VALID
);

  typedef enum logic [1:0] {OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU} own_e;
  typedef enum logic [1:0] {CPU_IDLE, CPU_PEND, CPU_BUSY, CPU_DONE} cpu_st_e;

  cpu_st_e       cpu_st_q, cpu_st_d;
  logic          cpu_pend;
  logic          bg_slot, spr_slot;
  logic          gnt_bg, gnt_spr, gnt_cpu;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  own_e          own_p1_q, own_p1_d, own_p2_q;
  logic          wr_p2_q;
  logic [DW-1:0] rdata_q, cpu_rdata_q;
  logic          bg_valid_q, spr_valid_q, cpu_ack_q;
  logic          hpos_unused;

  // Only the slot phase of HPOS matters; the upper bits are deliberately ignored.
  assign hpos_unused = ^HPOS[8:2];

  // Phase 3 of every 4-pixel group is always left free for the CPU.
  always_comb begin
    bg_slot  = 1'b0;
    spr_slot = 1'b0;
    if (!VBLK) begin
      if (HBLK) spr_slot = (HPOS[1:0] != 2'd3);
      else      bg_slot  = (HPOS[1:0] != 2'd3);
    end
  end

  assign gnt_bg  = PCLK_EN & bg_slot & BG_REQ;
  assign gnt_spr = PCLK_EN & spr_slot & SPR_REQ;
  assign gnt_cpu = PCLK_EN & ~gnt_bg & ~gnt_spr & cpu_pend;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cpu_st_q <= CPU_IDLE;
    else        cpu_st_q <= cpu_st_d;
  end

  // DONE waits for REQ to drop so a held request is never issued twice.
  always_comb begin
    cpu_st_d = cpu_st_q;
    case (cpu_st_q)
      CPU_IDLE: if (CPU_REQ)   cpu_st_d = CPU_PEND;
      CPU_PEND: if (gnt_cpu)   cpu_st_d = CPU_BUSY;
      CPU_BUSY: if (cpu_ack_q) cpu_st_d = CPU_DONE;
      CPU_DONE: if (!CPU_REQ)  cpu_st_d = CPU_IDLE;
      default:                 cpu_st_d = CPU_IDLE;
    endcase
  end

  always_comb begin
    cpu_pend = (cpu_st_q == CPU_PEND);
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    own_p1_d    = OWN_NONE;
    if (gnt_bg) begin
      mem_addr_d = BG_ADDR;
      own_p1_d   = OWN_BG;
    end else if (gnt_spr) begin
      mem_addr_d = SPR_ADDR;
      own_p1_d   = OWN_SPR;
    end else if (gnt_cpu) begin
      mem_addr_d  = CPU_ADDR;
      mem_wdata_d = CPU_WDATA;
      mem_we_d    = CPU_WE;
      own_p1_d    = OWN_CPU;
    end
  end

  // Issue stage: address/owner registered on the grant edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      own_p1_q    <= OWN_NONE;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      own_p1_q    <= own_p1_d;
    end
  end

  // RAM access stage: owner tracks the cycle the VRAM is producing data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      own_p2_q <= OWN_NONE;
      wr_p2_q  <= 1'b0;
    end else begin
      own_p2_q <= own_p1_q;
      wr_p2_q  <= mem_we_q;
    end
  end

  // Return stage: steer read data to its owner with a one-CLK strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_q     <= '0;
      cpu_rdata_q <= '0;
      bg_valid_q  <= 1'b0;
      spr_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      bg_valid_q  <= (own_p2_q == OWN_BG);
      spr_valid_q <= (own_p2_q == OWN_SPR);
      cpu_ack_q   <= (own_p2_q == OWN_CPU);
      if (own_p2_q == OWN_BG || own_p2_q == OWN_SPR) rdata_q <= MEM_RDATA;
      if (own_p2_q == OWN_CPU && !wr_p2_q)           cpu_rdata_q <= MEM_RDATA;
    end
  end

  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_WDATA = mem_wdata_q;
  assign RDATA     = rdata_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign BG_VALID  = bg_valid_q;
  assign SPR_VALID = spr_valid_q;
  assign CPU_ACK   = cpu_ack_q;

endmodule

// File: tb/tb_vram_slot_sched.sv
// Scoreboard bench for vram_slot_sched: a slot-level reference model predicts every
// grant and its returned data; a negedge monitor compares the DUT against it.
module tb_vram_slot_sched;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PCLK_EN = 1'b0;
  logic [8:0]  HPOS = '0;
  logic        HBLK = 1'b0, VBLK = 1'b0;
  logic        BG_REQ = 1'b0, SPR_REQ = 1'b0;
  logic [13:0] BG_ADDR = '0, SPR_ADDR = '0;
  logic        CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [13:0] CPU_ADDR = '0;
  logic [7:0]  CPU_WDATA = '0;
  logic        CPU_ACK, MEM_WE, BG_VALID, SPR_VALID;
  logic [7:0]  CPU_RDATA, MEM_WDATA, RDATA;
  logic [13:0] MEM_ADDR;
  logic [7:0]  MEM_RDATA = '0;

  vram_slot_sched #(.AW(14), .DW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .PCLK_EN(PCLK_EN), .HPOS(HPOS), .HBLK(HBLK), .VBLK(VBLK),
    .BG_REQ(BG_REQ), .BG_ADDR(BG_ADDR), .SPR_REQ(SPR_REQ), .SPR_ADDR(SPR_ADDR),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .RDATA(RDATA),
    .BG_VALID(BG_VALID), .SPR_VALID(SPR_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {int kind; logic [7:0] data; int due;} exp_t;  // kind 0 BG,1 SPR,2 CPU rd,3 CPU wr
  exp_t q[$];
  exp_t mon_e;

  int checks = 0, errors = 0;
  int cyc = 0;
  event slot_ev;
  bit cpu_done = 1'b0;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 157) ^ (i >> 6) ^ 90);
  endfunction

  // VRAM: synchronous single port, data one CLK after address.
  logic [7:0] ram [0:16383];
  bit ram_ready = 1'b0;
  always @(posedge CLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16384; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
      MEM_RDATA <= ram[MEM_ADDR];
    end
  end

  // Reference model: 0 free, 1 background, 2 sprite.
  function automatic int slot_class(input logic [8:0] hp, input logic hb, input logic vb);
    int ph8, ph4;
    ph8 = int'(hp) % 8;
    ph4 = int'(hp) % 4;
    if (vb) return 0;
    if (hb) return (ph4 == 3) ? 0 : 2;
    return (ph8 == 3 || ph8 == 7) ? 0 : 1;
  endfunction

  logic [7:0]  ref_mem [0:16383];
  bit          ref_ready = 1'b0;
  bit          cpu_pend = 1'b0, cpu_out = 1'b0, wr_pend = 1'b0;
  logic [13:0] wr_a = '0;
  logic [7:0]  wr_d = '0;
  bit          iss_chk = 1'b0, exp_we = 1'b0;
  logic [13:0] exp_addr = '0, last_addr = '0;
  logic [7:0]  exp_wdata = '0;

  always @(posedge CLK) begin
    int cls;
    if (!ref_ready) begin
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
      ref_ready = 1'b1;
    end
    cyc++;
    if (!RST_N) begin
      q.delete();
      cpu_pend = 0; cpu_out = 0; wr_pend = 0; iss_chk = 0; exp_we = 0; last_addr = '0;
    end else begin
      iss_chk = 0; exp_we = 0;
      if (wr_pend) begin ref_mem[wr_a] = wr_d; wr_pend = 0; end
      if (PCLK_EN) begin
        cls = slot_class(HPOS, HBLK, VBLK);
        if (cls == 1 && BG_REQ) begin
          q.push_back('{0, ref_mem[BG_ADDR], cyc + 2});
          iss_chk = 1; exp_addr = BG_ADDR;
        end else if (cls == 2 && SPR_REQ) begin
          q.push_back('{1, ref_mem[SPR_ADDR], cyc + 2});
          iss_chk = 1; exp_addr = SPR_ADDR;
        end else if (cpu_pend) begin
          q.push_back('{CPU_WE ? 3 : 2, ref_mem[CPU_ADDR], cyc + 2});
          iss_chk = 1; exp_addr = CPU_ADDR; exp_we = CPU_WE; exp_wdata = CPU_WDATA;
          if (CPU_WE) begin wr_pend = 1; wr_a = CPU_ADDR; wr_d = CPU_WDATA; end
          cpu_pend = 0;
        end
        if (iss_chk) last_addr = exp_addr;
      end
      if (CPU_REQ && !cpu_out) begin cpu_pend = 1; cpu_out = 1; end
      else if (!CPU_REQ && cpu_out && !cpu_pend) cpu_out = 0;
    end
  end

  function automatic logic [2:0] pulse_of(input int k);
    return (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
  endfunction

  logic [7:0] last_rdata = '0, last_cpu = '0;
  always @(negedge CLK) begin
    logic [2:0] want_p;
    bit exp_p;
    if (!RST_N) begin
      checks++;
      if ({CPU_ACK, CPU_RDATA, MEM_ADDR, MEM_WE, MEM_WDATA, RDATA, BG_VALID, SPR_VALID} != '0) begin
        errors++;
        $display("FAIL reset_outputs got ack=%b we=%b addr=%h bgv=%b sprv=%b rd=%h crd=%h want all 0",
                 CPU_ACK, MEM_WE, MEM_ADDR, BG_VALID, SPR_VALID, RDATA, CPU_RDATA);
      end
      last_rdata = '0; last_cpu = '0;
    end else begin
      checks++;
      if (iss_chk) begin
        if (MEM_ADDR !== exp_addr || MEM_WE !== exp_we || (exp_we && MEM_WDATA !== exp_wdata)) begin
          errors++;
          $display("FAIL issue got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                   MEM_ADDR, MEM_WE, MEM_WDATA, exp_addr, exp_we, exp_wdata);
        end
      end else if (MEM_ADDR !== last_addr || MEM_WE !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold got addr=%h we=%b want addr=%h we=0", MEM_ADDR, MEM_WE, last_addr);
      end
      exp_p  = (q.size() > 0) && (q[0].due == cyc);
      want_p = exp_p ? pulse_of(q[0].kind) : 3'b000;
      checks++;
      if ({BG_VALID, SPR_VALID, CPU_ACK} !== want_p) begin
        errors++;
        $display("FAIL pulse got bg/spr/ack=%b want %b (cyc %0d)", {BG_VALID, SPR_VALID, CPU_ACK}, want_p, cyc);
      end
      if (exp_p) begin
        mon_e = q.pop_front();
        checks++;
        case (mon_e.kind)
          0, 1: begin
            if (RDATA !== mon_e.data || CPU_RDATA !== last_cpu) begin
              errors++;
              $display("FAIL fetch_data got rd=%h crd=%h want rd=%h crd=%h", RDATA, CPU_RDATA, mon_e.data, last_cpu);
            end
            last_rdata = mon_e.data;
          end
          2: begin
            if (CPU_RDATA !== mon_e.data || RDATA !== last_rdata) begin
              errors++;
              $display("FAIL cpu_read got crd=%h rd=%h want crd=%h rd=%h", CPU_RDATA, RDATA, mon_e.data, last_rdata);
            end
            last_cpu = mon_e.data;
          end
          default: begin
            if (CPU_RDATA !== last_cpu || RDATA !== last_rdata) begin
              errors++;
              $display("FAIL cpu_write_hold got crd=%h rd=%h want crd=%h rd=%h", CPU_RDATA, RDATA, last_cpu, last_rdata);
            end
          end
        endcase
      end
    end
  end

  task automatic slot(input logic [8:0] hp, input logic hb, input logic vb, input logic br, input logic sr);
    @(negedge CLK);
    HPOS = hp; HBLK = hb; VBLK = vb; BG_REQ = br; SPR_REQ = sr;
    BG_ADDR = 14'($urandom); SPR_ADDR = 14'($urandom);
    PCLK_EN = 1'b1;
    -> slot_ev;
    @(negedge CLK);
    PCLK_EN = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  task automatic cpu_op(input logic we, input logic [13:0] a, input logic [7:0] d, input int hold);
    bit got;
    got = 1'b0;
    @(negedge CLK);
    CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d; CPU_REQ = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (CPU_ACK) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL cpu_ack_timeout got none want ack for addr %h", a); end
    repeat (hold) @(negedge CLK);
    CPU_REQ = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic wait_slot(input logic [8:0] hp);
    do @(slot_ev); while (HPOS != hp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every requester active.
    CPU_REQ = 1'b1;
    for (int i = 0; i < 6; i++) slot(9'(i + 288 * (i % 2)), 1'(i % 2), 1'b0, 1'b1, 1'b1);
    CPU_REQ = 1'b0;
    @(posedge CLK); #2 RST_N = 1'b1;

    // Active lines with background always requesting.
    for (int l = 0; l < 2; l++)
      for (int h = 0; h < 8; h++) slot(9'(h), 1'b0, 1'b0, 1'b1, 1'b0);

    // CPU read raised at HPOS 1, held well past its ack.
    fork
      begin for (int h = 0; h < 24; h++) slot(9'(h % 8), 1'b0, 1'b0, 1'b1, 1'b0); end
      begin wait_slot(9'd1); cpu_op(1'b0, 14'h1234, 8'h00, 6); end
    join

    // CPU write into a donated background slot, then read it back.
    fork
      begin for (int h = 0; h < 24; h++) slot(9'(h % 8), 1'b0, 1'b0, 1'b0, 1'b0); end
      begin cpu_op(1'b1, 14'h0100, 8'hA5, 2); cpu_op(1'b0, 14'h0100, 8'h00, 0); end
    join

    // Horizontal blank sprite fetch with a CPU request waiting.
    fork
      begin repeat (2) @(negedge CLK); for (int h = 288; h < 304; h++) slot(9'(h), 1'b1, 1'b0, 1'b0, 1'b1); end
      begin cpu_op(1'b0, 14'h0100, 8'h00, 1); end
    join

    // Vertical blank write burst with a reset during the third write.
    cpu_done = 1'b0;
    fork
      begin for (int n = 0; n < 20 || !cpu_done; n++) slot(9'(n), 1'b0, 1'b1, 1'b1, 1'b1); end
      begin
        bit seen;
        cpu_op(1'b1, 14'h0200, 8'h11, 0);
        cpu_op(1'b1, 14'h0201, 8'h22, 0);
        @(negedge CLK);
        CPU_WE = 1'b1; CPU_ADDR = 14'h0202; CPU_WDATA = 8'h33; CPU_REQ = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
          @(negedge CLK);
          if (MEM_WE) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL third_write_issue got none want MEM_WE"); end
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        CPU_REQ = 1'b0;
        @(posedge CLK); #2 RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        cpu_op(1'b1, 14'h0203, 8'h44, 0);
        cpu_op(1'b0, 14'h0202, 8'h00, 0);
        cpu_op(1'b0, 14'h0201, 8'h00, 0);
        cpu_done = 1'b1;
      end
    join

    // Random traffic over all slot classes.
    cpu_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 150 || !cpu_done; n++)
          slot(9'($urandom_range(0, 511)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               1'($urandom), 1'($urandom));
      end
      begin
        for (int k = 0; k < 20; k++)
          cpu_op(1'($urandom), 14'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 3));
        cpu_done = 1'b1;
      end
    join

    repeat (8) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain got %0d pending want 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
